key_emulator: RTL

KEY_EMULATOR -- requirements
Module: key_emulator

---
 rtl/key_emu_pkg.sv | 23 ++
 rtl/key_emulator_if.sv | 21 ++
 rtl/key_emulator_lfsr.sv | 34 +++
 rtl/key_emulator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/key_emu_pkg.sv
// Shared types and helpers for the key emulator: FSM state encoding,
// LFSR width/seed/taps and the ns-to-cycles conversion.
package key_emu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        GAP
    } state_e;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Whole clock cycles covered by a duration in ns at a clock of mhz MHz.
    function automatic int cycles_from_ns(input int ns, input int mhz);
        return (ns * mhz) / 1000;
    endfunction

endpackage

// File: rtl/key_emulator_if.sv
// Request/status bundle of the key emulator. The controller drives the
// request side (master); the emulator drives the status side (slave).
interface key_emulator_if;

    logic press_req_i;
    logic abort_i;
    logic ready_o;
    logic key_o;
    logic done_stb_o;

    modport master (
        output press_req_i, abort_i,
        input  ready_o, key_o, done_stb_o
    );

    modport slave (
        input  press_req_i, abort_i,
        output ready_o, key_o, done_stb_o
    );

endinterface

// File: rtl/key_emulator_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) that supplies the pseudo-random
// bounce intervals. Advances only when en_i is high.
module lfsr
    import key_emu_pkg::*;
(
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              en_i,
    output logic [LFSR_W-1:0] value_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next value: shift right, fold the output bit back through the taps.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    // State register; the seed must be nonzero or the sequence locks up.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/key_emulator.sv
// Key emulator: on request, produces a raw key waveform with contact bounce
// on press and release, a stable hold, and a quiet gap before going idle.
// Define KEY_EMU_BOUNCE_EN to build the bounce windows and the LFSR; without
// it a press is a clean HOLD pulse followed by the GAP.
module key_emulator
    import key_emu_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 100,
    parameter int HOLD_TIME_NS   = 1000,
    parameter int BOUNCE_TIME_NS = 100,
    parameter int BOUNCE_EDGES   = 4
) (
    input  logic           clk_i,
    input  logic           srst_n_i,
    key_emulator_if.slave  bus
);

    localparam int HOLD_RAW   = cycles_from_ns(HOLD_TIME_NS, CLK_FREQ_MHZ);
    localparam int HOLD_CYC   = (HOLD_RAW > 1) ? HOLD_RAW : 1;
    localparam int BOUNCE_RAW = cycles_from_ns(BOUNCE_TIME_NS, CLK_FREQ_MHZ);
    localparam int BOUNCE_CYC = (BOUNCE_RAW > BOUNCE_EDGES) ? BOUNCE_RAW : BOUNCE_EDGES;
    localparam int CNT_MAX    = (HOLD_CYC > BOUNCE_CYC) ? HOLD_CYC : BOUNCE_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BOUNCE_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q, key_d;
    logic             done_q, done_d;

`ifdef KEY_EMU_BOUNCE_EN
    localparam int STEP   = BOUNCE_CYC / BOUNCE_EDGES;
    localparam int EDGE_W = $clog2(BOUNCE_EDGES) + 1;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(BOUNCE_EDGES - 1);

    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [LFSR_W-1:0] lfsr_val;
    logic              lfsr_step;
    logic [CNT_W-1:0]  interval_last;

    lfsr u_lfsr (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .en_i     (lfsr_step),
        .value_o  (lfsr_val)
    );

    // Interval before the next toggle is (lfsr mod STEP)+1 cycles; the
    // counter starts at 0, so the toggle fires when it equals lfsr mod STEP.
    assign interval_last = CNT_W'(lfsr_val % LFSR_W'(STEP));
`endif

    // Next-state and output decode of the press sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done_d  = 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
        edge_d    = edge_q;
        lfsr_step = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.press_req_i) begin
                    key_d = 1'b1;
                    cnt_d = '0;
`ifdef KEY_EMU_BOUNCE_EN
                    state_d = PRESS_BOUNCE;
                    edge_d  = '0;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef KEY_EMU_BOUNCE_EN
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (bus.abort_i) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    key_d   = 1'b0;
                end else if (cnt_q == interval_last) begin
                    key_d     = ~key_q;
                    cnt_d     = '0;
                    lfsr_step = 1'b1;
                    edge_d    = edge_q + 1'b1;
                    if (edge_q == EDGE_LAST) begin
                        state_d = (state_q == PRESS_BOUNCE) ? HOLD : GAP;
                        edge_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            HOLD: begin
                if (bus.abort_i) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    key_d   = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    key_d = 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
                    state_d = RELEASE_BOUNCE;
                    edge_d  = '0;
`else
                    state_d = GAP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                key_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any sequence without a strobe.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!srst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
            edge_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            done_q  <= done_d;
`ifdef KEY_EMU_BOUNCE_EN
            edge_q  <= edge_d;
`endif
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.key_o      = key_q;
    assign bus.done_stb_o = done_q;

endmodule
